// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: pipelined multiplier with accumulate modes and a
// restoring radix-2 divider. One operation in flight at a time.
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             Clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             done
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 3);

  typedef enum logic [3:0] {
    OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
    OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e        state;
  logic [CW-1:0] cnt;

  logic launch, is_mul, is_div, is_signed;
  always_comb begin
    launch    = start && !Busy && !cancel;
    is_mul    = (op <= OP_MSUBU);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed = !op[0];
  end

  // Multiplier datapath: operands extended to 2*WIDTH so one truncated
  // product serves both signed and unsigned variants.
  logic [DW-1:0] mul_a, mul_b;
  logic [DW-1:0] mul_pipe [MUL_LAT-1];
  logic [1:0]    acc_mode;   // op[2:1]: 0 set, 1 add, 2 subtract

  // Divider datapath
  logic [WIDTH-1:0] quo, rem, dsr, div_a_raw;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   rem_shift, rem_diff;

  // NOTE: datapath registers carry no reset; state and cnt alone decide
  // whether their contents are meaningful, so reset is kept off the wide paths.
  always_ff @(posedge Clk) begin
    if (launch && is_mul) begin
      mul_a    <= is_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
      mul_b    <= is_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
      acc_mode <= op[2:1];
    end
    mul_pipe[0] <= mul_a * mul_b;
    for (int i = 1; i < MUL_LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];

    if (launch && is_div) begin
      quo       <= A;
      dsr       <= B;
      div_a_raw <= A;
      a_neg     <= is_signed && A[WIDTH-1];
      b_neg     <= is_signed && B[WIDTH-1];
    end else if (state == S_DIV && cnt == CW'(WIDTH + 2)) begin
      quo <= a_neg ? -quo : quo;
      dsr <= b_neg ? -dsr : dsr;
      rem <= '0;
    end else if (state == S_DIV && cnt >= CW'(2)) begin
      if (!rem_diff[WIDTH]) begin
        rem <= rem_diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_shift[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  logic [DW-1:0]    mul_res;
  logic [WIDTH-1:0] div_hi, div_lo;
  // NOTE: combinational blocks use blocking assignments and give every
  // output a value on every path, so no latch is inferred.
  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dsr};
    case (acc_mode)
      2'd1:    mul_res = {HI, LO} + mul_pipe[MUL_LAT-2];
      2'd2:    mul_res = {HI, LO} - mul_pipe[MUL_LAT-2];
      default: mul_res = mul_pipe[MUL_LAT-2];
    endcase
    if (dsr == '0) begin
      div_lo = {WIDTH{1'b1}};
      div_hi = div_a_raw;
    end else begin
      div_lo = (a_neg ^ b_neg) ? -quo : quo;
      div_hi = a_neg ? -rem : rem;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      Busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (Busy && cancel) begin
        state <= S_IDLE;
        cnt   <= '0;
        Busy  <= 1'b0;
      end else if (Busy) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          done  <= 1'b1;
          if (state == S_MUL) {HI, LO} <= mul_res;
          else                {HI, LO} <= {div_hi, div_lo};
        end
      end else if (launch) begin
        if (is_mul) begin
          state <= S_MUL;
          cnt   <= CW'(MUL_LAT);
          Busy  <= 1'b1;
        end else if (is_div) begin
          state <= S_DIV;
          cnt   <= CW'(WIDTH + 2);
          Busy  <= 1'b1;
        end else if (op == OP_MTHI) begin
          HI <= A;
        end else if (op == OP_MTLO) begin
          LO <= A;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at WIDTH=32, MUL_LAT=4.
module tb_mul_div_unit;
  localparam int WIDTH = 32;

  logic             Clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       op = 4'hf;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             cancel = 1'b0;
  logic [WIDTH-1:0] HI, LO;
  logic             Busy, done;

  int n_vec  = 0;
  int n_miss = 0;

  mul_div_unit #(.WIDTH(WIDTH), .MUL_LAT(4)) dut (
    .Clk(Clk), .resetn(resetn), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .HI(HI), .LO(LO), .Busy(Busy), .done(done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle start pulse from a falling edge.
  task automatic pulse(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge Clk);
    start = 1'b0; op = 4'hf; A = '0; B = '0;
  endtask

  // Launch an op, count Busy cycles (bounded) and done pulses.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy, input int exp_done);
    int cyc;
    int ndone;
    pulse(o, a, b);
    cyc = 0;
    ndone = 0;
    while (Busy && cyc < 200) begin
      if (done) ndone++;
      cyc++;
      @(negedge Clk);
    end
    if (done) ndone++;
    @(negedge Clk);
    if (done) ndone++;
    check({tag, "_busy"}, 64'(cyc), 64'(exp_busy));
    check({tag, "_done"}, 64'(ndone), 64'(exp_done));
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    check({tag, "_hilo"}, {HI, LO}, {hi, lo});
  endtask

  initial begin
    int ndone;
    repeat (2) @(negedge Clk);
    check("rst_hilo", {HI, LO}, 64'h0);
    check("rst_busy_done", {62'h0, Busy, done}, 64'h0);
    resetn = 1'b1;

    run_op("mult", 4'd0, 32'hFFFFFFFF, 32'd2, 4, 1);
    check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);

    run_op("multu", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 1);
    check_hilo("multu", 32'hFFFFFFFE, 32'h00000001);
    run_op("maddu", 4'd3, 32'd1, 32'd1, 4, 1);
    check_hilo("maddu", 32'hFFFFFFFE, 32'h00000002);

    run_op("mthi0", 4'd8, 32'd0, 32'd0, 0, 0);
    run_op("mtlo0", 4'd9, 32'd0, 32'd0, 0, 0);
    run_op("msub", 4'd4, 32'd3, 32'd5, 4, 1);
    check_hilo("msub", 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("madd", 4'd2, 32'hFFFFFFFE, 32'd4, 4, 1);
    check_hilo("madd", 32'hFFFFFFFF, 32'hFFFFFFE9);
    run_op("msubu", 4'd5, 32'h80000000, 32'd2, 4, 1);
    check_hilo("msubu", 32'hFFFFFFFE, 32'hFFFFFFE9);

    run_op("div_neg", 4'd6, 32'hFFFFFFF9, 32'd2, 34, 1);
    check_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb", 4'd6, 32'd7, 32'hFFFFFFFE, 34, 1);
    check_hilo("div_negb", 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_zero", 4'd7, 32'd7, 32'd0, 34, 1);
    check_hilo("divu_zero", 32'h00000007, 32'hFFFFFFFF);
    run_op("div_ovf", 4'd6, 32'h80000000, 32'hFFFFFFFF, 34, 1);
    check_hilo("div_ovf", 32'h00000000, 32'h80000000);
    run_op("divu", 4'd7, 32'd100, 32'd7, 34, 1);
    check_hilo("divu", 32'h00000002, 32'h0000000E);
    run_op("divu_big", 4'd7, 32'hFFFFFFFF, 32'h00010000, 34, 1);
    check_hilo("divu_big", 32'h0000FFFF, 32'h0000FFFF);

    // MTHI takes effect at the launching edge with no Busy
    @(negedge Clk);
    start = 1'b1; op = 4'd8; A = 32'h1234;
    @(negedge Clk);
    start = 1'b0; op = 4'hf;
    check("mthi_val", 64'(HI), 64'h1234);
    check("mthi_busy", 64'(Busy), 64'h0);

    // MTLO attempted while a divide is busy is ignored
    run_op("mtlo_pre", 4'd9, 32'h12345678, 32'd0, 0, 0);
    pulse(4'd7, 32'd100, 32'd7);
    repeat (2) @(negedge Clk);
    start = 1'b1; op = 4'd9; A = 32'hDEAD;
    @(negedge Clk);
    start = 1'b0; op = 4'hf;
    check("mtlo_busy_lo", 64'(LO), 64'h12345678);
    check("mtlo_busy_busy", 64'(Busy), 64'h1);
    for (int i = 0; i < 60 && Busy; i++) @(negedge Clk);
    check_hilo("div_after_mtlo", 32'h00000002, 32'h0000000E);

    // cancel in the 10th divide cycle
    run_op("pre_hi", 4'd8, 32'hAAAA5555, 32'd0, 0, 0);
    run_op("pre_lo", 4'd9, 32'h0F0F0F0F, 32'd0, 0, 0);
    pulse(4'd6, 32'd1000, 32'd3);
    repeat (9) @(negedge Clk);
    cancel = 1'b1;
    @(negedge Clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(Busy), 64'h0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge Clk);
    end
    check("cancel_done", 64'(ndone), 64'h0);
    check_hilo("cancel", 32'hAAAA5555, 32'h0F0F0F0F);

    // cancel coinciding with the multiply write-back edge
    pulse(4'd0, 32'd3, 32'd5);
    repeat (3) @(negedge Clk);
    cancel = 1'b1;
    @(negedge Clk);
    cancel = 1'b0;
    check("cancel_wb_busy_done", {62'h0, Busy, done}, 64'h0);
    check_hilo("cancel_wb", 32'hAAAA5555, 32'h0F0F0F0F);

    // cancel with start in idle: MTHI must not write
    @(negedge Clk);
    start = 1'b1; cancel = 1'b1; op = 4'd8; A = 32'h55;
    @(negedge Clk);
    start = 1'b0; cancel = 1'b0; op = 4'hf;
    check("cancel_start", {HI, 31'h0, Busy}, {32'hAAAA5555, 32'h0});

    // unused op code leaves everything alone
    run_op("unused", 4'd12, 32'h11, 32'h22, 0, 0);
    check_hilo("unused", 32'hAAAA5555, 32'h0F0F0F0F);

    // asynchronous reset in the middle of a multiply
    pulse(4'd0, 32'hFFFFFFFF, 32'd2);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_hilo", {HI, LO}, 64'h0);
    check("async_rst_busy_done", {62'h0, Busy, done}, 64'h0);
    @(negedge Clk);
    resetn = 1'b1;
    run_op("post_rst", 4'd0, 32'd3, 32'd5, 4, 1);
    check_hilo("post_rst", 32'h0, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width, even and at least 8.
REQ-002 SHALL have parameter MUL_LAT, default 4, range 2..8: cycles from multiply start to the HI/LO update.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: launches op when Busy=0.
REQ-006 SHALL have port op, input, 4 bits: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU, 8 MTHI, 9 MTLO; others are no-ops.
REQ-007 SHALL have ports A and B, inputs, WIDTH bits each: operands; A is also the MTHI/MTLO data.
REQ-008 SHALL have port cancel, input, 1 bit: aborts the in-flight op (exception flush).
REQ-009 SHALL have ports HI and LO, outputs, WIDTH bits each: architectural registers.
REQ-010 SHALL have port Busy, output, 1 bit: operation in flight.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse in the cycle HI/LO take a mul/div result.

Function
REQ-012 SHALL sample start, op, A and B only when start=1 and Busy=0; start while Busy=1 SHALL be ignored, with no queueing.
REQ-013 MTHI/MTLO with Busy=0 SHALL write A to HI/LO at the same edge, without asserting Busy or done.
REQ-014 Multiply ops SHALL form a 2*WIDTH-bit product, signed for MULT/MADD/MSUB and unsigned for the U variants, via a MUL_LAT-deep pipeline.
REQ-015 MULT/MULTU SHALL set {HI,LO}=product; MADD(U) SHALL set {HI,LO}+=product; MSUB(U) SHALL set {HI,LO}-=product; all arithmetic is modulo 2^(2*WIDTH).
REQ-016 Accumulate ops SHALL use HI/LO as they stand at the write-back edge.
REQ-017 For multiply ops, Busy SHALL rise the cycle after start and stay high for MUL_LAT cycles; HI/LO update and done pulse at the edge ending the last Busy cycle, and Busy=0 the next cycle.
REQ-018 DIV/DIVU SHALL use an iterative radix-2 non-restoring or restoring divider over magnitudes, one quotient bit per cycle.
REQ-019 For divide ops, Busy SHALL stay high WIDTH+2 cycles (1 setup, WIDTH iterations, 1 sign fix) before the HI/LO update.
REQ-020 Divide results: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
REQ-021 Divide by zero (B=0) SHALL give LO=all ones and HI=A, with full latency and done asserted.
REQ-022 Signed overflow (A=-2^(WIDTH-1), B=-1) SHALL give LO=A and HI=0.
REQ-023 State machine: IDLE -> MUL (counter MUL_LAT) or DIV (counter WIDTH+2) -> IDLE; Busy=1 exactly in MUL and DIV.
REQ-024 cancel=1 SHALL return the FSM to IDLE at the next edge, leave HI/LO unchanged, and suppress done; cancel in IDLE has no effect.
REQ-025 cancel and start in the same cycle with Busy=0 SHALL give cancel priority: the op is not launched and MTHI/MTLO do not write.
REQ-026 If cancel and the final write-back edge coincide, cancel SHALL win: no write and no done.
REQ-027 Unused op codes with start=1 SHALL leave all state unchanged.

Reset
REQ-028 resetn=0 SHALL asynchronously force HI=0, LO=0, Busy=0, done=0, FSM=IDLE and clear all counters.
REQ-029 The multiplier pipeline datapath registers need no reset, but their valid tracking SHALL reset.
REQ-030 Reset mid-operation SHALL discard the op; after resetn rises, the first start SHALL be accepted normally.

Verification (WIDTH=32, MUL_LAT=4)
REQ-031 MULT A=0xFFFFFFFF, B=2 -> Busy for 4 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE, done pulse of 1 cycle.
REQ-032 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then MADDU A=1, B=1 -> LO=0x00000002.
REQ-033 DIV A=-7, B=2 -> Busy for 34 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
REQ-034 DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; MSUB from HI/LO=0 with A=3, B=5 -> {HI,LO}=-15.
REQ-035 MTHI A=0x1234 -> HI=0x1234 next cycle, with no Busy; start of MTLO while a DIV is busy -> ignored, LO unchanged.
REQ-036 cancel at DIV cycle 10 -> Busy=0 next cycle, HI/LO unchanged, no done; resetn pulse mid-MULT -> all outputs 0 asynchronously.
